// File: rtl/rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// rom_fetch_arbiter
//
// Purpose:
//    Sequencer and two-port round-robin arbiter for the split program ROM
//    (MemoriesROM). This block is the only driver of ROMEnable/AddressROM.
//    It issues one synchronous ROM read at a time and returns each
//    Instruction word to the port that requested it.
//
// Handshake (both ports):
//    A requester raises ReqN with a stable AddrN and holds both until it
//    sees GntN. GntN is a one-cycle accept pulse. The requester drops ReqN,
//    or moves AddrN on to its next address, at the edge after GntN. A ReqN
//    still high when the arbiter next samples it counts as a new request.
//    ValidN is a one-cycle pulse that marks a new word in DataN. DataN
//    holds that word until the next capture for the same port.
//
// Ports:
//    CLK          in   clock shared with MemoriesROM
//    RSTn         in   synchronous active-low reset
//    Req0/Req1    in   read request, port 0 (fetch) / port 1 (debug/loader)
//    Addr0/Addr1  in   ROM word address for each port
//    Gnt0/Gnt1    out  one-cycle accept pulse
//    Valid0/1     out  one-cycle pulse, Data0/1 holds a new word
//    Data0/Data1  out  last word returned to each port
//    ROMEnable    out  ROM read strobe (MemoriesROM.ROMEnable)
//    AddressROM   out  ROM word address (MemoriesROM.AddressROM)
//    Instruction  in   ROM read data, valid the cycle after the strobe
//    Busy         out  high while a read is in flight (FETCH or WAIT)
//    StateDbg     out  current FSM state (0 IDLE, 1 FETCH, 2 WAIT)
// -----------------------------------------------------------------------------
module rom_fetch_arbiter #(
   parameter int WidthInstruction = 32,
   parameter int ROM_ADDR_BITS    = 4
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   input  logic                        Req0,
   input  logic [ROM_ADDR_BITS-1:0]    Addr0,
   output logic                        Gnt0,
   output logic                        Valid0,
   output logic [WidthInstruction-1:0] Data0,
   input  logic                        Req1,
   input  logic [ROM_ADDR_BITS-1:0]    Addr1,
   output logic                        Gnt1,
   output logic                        Valid1,
   output logic [WidthInstruction-1:0] Data1,
   output logic                        ROMEnable,
   output logic [ROM_ADDR_BITS-1:0]    AddressROM,
   input  logic [WidthInstruction-1:0] Instruction,
   output logic                        Busy,
   output logic [1:0]                  StateDbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic                        owner_q, owner_d;   // port whose read is in flight
   logic                        prio_q, prio_d;     // port favoured on a tie
   logic                        gnt0_q, gnt0_d;
   logic                        gnt1_q, gnt1_d;
   logic                        valid0_q, valid0_d;
   logic                        valid1_q, valid1_d;
   logic [WidthInstruction-1:0] data0_q, data0_d;
   logic [WidthInstruction-1:0] data1_q, data1_d;
   logic                        en_q, en_d;
   logic [ROM_ADDR_BITS-1:0]    addr_q, addr_d;
   logic                        busy_q, busy_d;

   // Arbitration helpers
   logic do_arb;   // requests are sampled this cycle
   logic arb_ptr;  // tie-break pointer in effect this cycle
   logic winner;   // port that wins when do_arb and any request is set

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      data0_d  = data0_q;
      data1_d  = data1_q;
      en_d     = 1'b0;
      addr_d   = addr_q;
      do_arb   = 1'b0;
      arb_ptr  = prio_q;
      winner   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            do_arb = 1'b1;
         end
         ST_FETCH: begin
            // ROM samples AddressROM at the end of this cycle.
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (owner_q) begin
               data1_d  = Instruction;
               valid1_d = 1'b1;
            end else begin
               data0_d  = Instruction;
               valid0_d = 1'b1;
            end
            // The pointer moves past the port just served, and the
            // re-arbitration in this same cycle already uses the new value.
            prio_d  = ~owner_q;
            arb_ptr = ~owner_q;
            do_arb  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_arb && (Req0 || Req1)) begin
         winner  = (Req0 && Req1) ? arb_ptr : Req1;
         owner_d = winner;
         gnt0_d  = ~winner;
         gnt1_d  = winner;
         en_d    = 1'b1;
         addr_d  = winner ? Addr1 : Addr0;
         state_d = ST_FETCH;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         prio_q   <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         data0_q  <= '0;
         data1_q  <= '0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         en_q     <= en_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
      end
   end

   assign Gnt0       = gnt0_q;
   assign Gnt1       = gnt1_q;
   assign Valid0     = valid0_q;
   assign Valid1     = valid1_q;
   assign Data0      = data0_q;
   assign Data1      = data1_q;
   assign ROMEnable  = en_q;
   assign AddressROM = addr_q;
   assign Busy       = busy_q;
   assign StateDbg   = state_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_fetch_arbiter
//
// Bench for rom_fetch_arbiter with a synchronous-read ROM model. A table of
// cycle vectors covers reset, contention and a single read. Hand-written
// sequences cover back-to-back reads, reset during a read and idle gaps.
// Each vector drives the inputs at a falling edge. Its expected outputs are
// sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_rom_fetch_arbiter;

   localparam int W  = 32;
   localparam int AW = 4;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic          RSTn = 1'b0;
   logic          Req0 = 1'b0, Req1 = 1'b0;
   logic [AW-1:0] Addr0 = '0, Addr1 = '0;
   logic          Gnt0, Gnt1, Valid0, Valid1, ROMEnable, Busy;
   logic [W-1:0]  Data0, Data1;
   logic [AW-1:0] AddressROM;
   logic [W-1:0]  Instruction = '0;
   logic [1:0]    StateDbg;

   rom_fetch_arbiter #(.WidthInstruction(W), .ROM_ADDR_BITS(AW)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .Req0(Req0), .Addr0(Addr0), .Gnt0(Gnt0), .Valid0(Valid0), .Data0(Data0),
      .Req1(Req1), .Addr1(Addr1), .Gnt1(Gnt1), .Valid1(Valid1), .Data1(Data1),
      .ROMEnable(ROMEnable), .AddressROM(AddressROM), .Instruction(Instruction),
      .Busy(Busy), .StateDbg(StateDbg)
   );

   // ---------------- ROM model ----------------
   function automatic logic [W-1:0] rw(input logic [AW-1:0] a);
      if (a == 4'd5) return 32'hDEADBEEF;
      return {24'hC0DE00, a, a};
   endfunction

   always @(posedge CLK) begin
      if (ROMEnable) Instruction <= rw(AddressROM);
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int v0_count = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Cycle-wide properties: single grant, single valid, no two-cycle strobe.
   logic prev_en = 1'b0;
   always @(negedge CLK) begin
      chk("onehot_gnt", {31'd0, Gnt0 & Gnt1}, 32'd0);
      chk("onehot_valid", {31'd0, Valid0 & Valid1}, 32'd0);
      chk("en_consecutive", {31'd0, prev_en & ROMEnable}, 32'd0);
      prev_en = ROMEnable;
      if (Valid0) v0_count++;
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic          rstn, r0, r1;
      logic [AW-1:0] a0, a1;
      logic          g0, g1, v0, v1, en, bz;
      logic [AW-1:0] ad;
      logic [W-1:0]  d0, d1;
   } vec_t;

   function automatic vec_t mk(
      input logic rstn, input logic r0, input logic [AW-1:0] a0,
      input logic r1, input logic [AW-1:0] a1,
      input logic g0, input logic g1, input logic v0, input logic v1,
      input logic en, input logic [AW-1:0] ad, input logic bz,
      input logic [W-1:0] d0, input logic [W-1:0] d1);
      vec_t v;
      v.rstn = rstn; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
      v.en = en; v.ad = ad; v.bz = bz; v.d0 = d0; v.d1 = d1;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      RSTn  = v.rstn;
      Req0  = v.r0;
      Addr0 = v.a0;
      Req1  = v.r1;
      Addr1 = v.a1;
      @(posedge CLK);
      #1;
      chk({tag, ".gnt0"}, {31'd0, Gnt0}, {31'd0, v.g0});
      chk({tag, ".gnt1"}, {31'd0, Gnt1}, {31'd0, v.g1});
      chk({tag, ".valid0"}, {31'd0, Valid0}, {31'd0, v.v0});
      chk({tag, ".valid1"}, {31'd0, Valid1}, {31'd0, v.v1});
      chk({tag, ".rom_en"}, {31'd0, ROMEnable}, {31'd0, v.en});
      chk({tag, ".addr"}, {28'd0, AddressROM}, {28'd0, v.ad});
      chk({tag, ".busy"}, {31'd0, Busy}, {31'd0, v.bz});
      chk({tag, ".data0"}, Data0, v.d0);
      chk({tag, ".data1"}, Data1, v.d1);
      @(negedge CLK);
   endtask

   vec_t tbl[25];

   initial begin
      logic [W-1:0] w1, w2, d0e, d1e;
      int v0_start;
      w1 = rw(4'd1);
      w2 = rw(4'd2);

      // Reset held with both requests up, then contention on addresses 1/2.
      for (int i = 0; i < 3; i++)
         tbl[i] = mk(0, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0,  0, 0);
      tbl[3]  = mk(1, 1, 1, 1, 2,  1, 0, 0, 0, 1, 1, 1,  0,  0);
      tbl[4]  = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 1, 1,  0,  0);
      tbl[5]  = mk(1, 1, 1, 1, 2,  0, 1, 1, 0, 1, 2, 1,  w1, 0);
      tbl[6]  = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 2, 1,  w1, 0);
      tbl[7]  = mk(1, 1, 1, 1, 2,  1, 0, 0, 1, 1, 1, 1,  w1, w2);
      tbl[8]  = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 1, 1,  w1, w2);
      tbl[9]  = mk(1, 1, 1, 1, 2,  0, 1, 1, 0, 1, 2, 1,  w1, w2);
      tbl[10] = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 2, 1,  w1, w2);
      tbl[11] = mk(1, 1, 1, 1, 2,  1, 0, 0, 1, 1, 1, 1,  w1, w2);
      tbl[12] = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 1, 1,  w1, w2);
      tbl[13] = mk(1, 1, 1, 1, 2,  0, 1, 1, 0, 1, 2, 1,  w1, w2);
      tbl[14] = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 2, 1,  w1, w2);
      tbl[15] = mk(1, 1, 1, 1, 2,  1, 0, 0, 1, 1, 1, 1,  w1, w2);
      tbl[16] = mk(1, 1, 1, 1, 2,  0, 0, 0, 0, 0, 1, 1,  w1, w2);
      tbl[17] = mk(1, 1, 1, 1, 2,  0, 1, 1, 0, 1, 2, 1,  w1, w2);
      tbl[18] = mk(1, 0, 1, 0, 2,  0, 0, 0, 0, 0, 2, 1,  w1, w2);
      tbl[19] = mk(1, 0, 1, 0, 2,  0, 0, 0, 1, 0, 2, 0,  w1, w2);
      tbl[20] = mk(1, 0, 1, 0, 2,  0, 0, 0, 0, 0, 2, 0,  w1, w2);
      // Single read of word 5, port 1 data must be left alone.
      tbl[21] = mk(1, 1, 5, 0, 0,  1, 0, 0, 0, 1, 5, 1,  w1, w2);
      tbl[22] = mk(1, 0, 5, 0, 0,  0, 0, 0, 0, 0, 5, 1,  w1, w2);
      tbl[23] = mk(1, 0, 5, 0, 0,  0, 0, 1, 0, 0, 5, 0,  32'hDEADBEEF, w2);
      tbl[24] = mk(1, 0, 5, 0, 0,  0, 0, 0, 0, 0, 5, 0,  32'hDEADBEEF, w2);

      @(negedge CLK);
      for (int i = 0; i < 25; i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
         if (i == 2) chk("state_reset", {30'd0, StateDbg}, 32'd0);
      end

      // Back-to-back reads on port 0 over the whole address range.
      v0_start = v0_count;
      d0e = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) d0e = rw(AW'(i - 1));
         apply(mk(1, 1, AW'(i), 0, 0,  1, 0, (i > 0), 0, 1, AW'(i), 1,  d0e, w2),
               $sformatf("b2b_gnt%0d", i));
         apply(mk(1, 1, AW'(i), 0, 0,  0, 0, 0, 0, 0, AW'(i), 1,  d0e, w2),
               $sformatf("b2b_fetch%0d", i));
      end
      d0e = rw(4'hF);
      apply(mk(1, 0, 4'hF, 0, 0,  0, 0, 1, 0, 0, 4'hF, 0,  d0e, w2), "b2b_last");
      #1;
      chk("b2b_valid0_pulses", v0_count - v0_start, 32'd16);

      // Reset during FETCH discards the read.
      apply(mk(1, 0, 0, 1, 3,  0, 1, 0, 0, 1, 3, 1,  d0e, w2), "rst_gnt");
      apply(mk(0, 0, 0, 1, 3,  0, 0, 0, 0, 0, 0, 0,  0, 0), "rst_fetch");
      apply(mk(1, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0,  0, 0), "rst_quiet0");
      apply(mk(1, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0,  0, 0), "rst_quiet1");
      apply(mk(1, 0, 0, 1, 9,  0, 1, 0, 0, 1, 9, 1,  0, 0), "rst_new_gnt");
      apply(mk(1, 0, 0, 0, 9,  0, 0, 0, 0, 0, 9, 1,  0, 0), "rst_new_fetch");
      apply(mk(1, 0, 0, 0, 9,  0, 0, 0, 1, 0, 9, 0,  0, rw(4'd9)), "rst_new_valid");

      // Port 1 requests separated by idle gaps of 0..5 cycles.
      d1e = rw(4'd9);
      for (int g = 0; g < 6; g++) begin
         logic [AW-1:0] a;
         a = AW'(g + 10);
         apply(mk(1, 0, 0, 1, a,  0, 1, 0, 0, 1, a, 1,  0, d1e), $sformatf("gap%0d_gnt", g));
         apply(mk(1, 0, 0, 0, a,  0, 0, 0, 0, 0, a, 1,  0, d1e), $sformatf("gap%0d_fetch", g));
         d1e = rw(a);
         apply(mk(1, 0, 0, 0, a,  0, 0, 0, 1, 0, a, 0,  0, d1e), $sformatf("gap%0d_valid", g));
         for (int k = 0; k < g; k++)
            apply(mk(1, 0, 0, 0, a,  0, 0, 0, 0, 0, a, 0,  0, d1e), $sformatf("gap%0d_idle%0d", g, k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound on the run.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
